// File: rtl/sign_mag_accum_ctrl.sv
// sign_mag_accum_ctrl
//
// Accumulates a programmed number of N-bit sign-magnitude operands.
// Operands arrive one per cycle on a valid/ready stream. Each accepted
// operand passes through a single shared sign-magnitude add step. The
// final sum goes out on a second valid/ready handshake, together with a
// sticky saturation flag.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset
//   start     in   1      begin a new accumulation (honoured only in IDLE)
//   len       in   CNT_W  number of terms, sampled with start
//   in_data   in   N      sign-magnitude operand (bit N-1 = sign)
//   in_valid  in   1      in_data is valid
//   in_ready  out  1      operand accepted this cycle (high in ACC)
//   out_sum   out  N      final sign-magnitude sum (valid in DONE)
//   out_ovf   out  1      at least one add in this run saturated
//   out_valid out  1      out_sum/out_ovf are valid (high in DONE)
//   out_ready in   1      consumer accepts the result
//   busy      out  1      high in ACC or DONE
module sign_mag_accum_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int MW = N - 1;
  localparam logic [MW-1:0] MAG_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic             signAcc, signIn, signRes;
  logic [MW-1:0]    magAcc, magIn, magRes;
  logic [N-1:0]     magSum;
  logic             addOvf;
  logic [CNT_W-1:0] lenLast;

  // Shared add step. Magnitudes are summed one bit wider than the
  // magnitude field so the carry out tells us the result no longer fits
  // and must saturate. Opposite signs subtract the smaller magnitude from
  // the larger one, which can never overflow. A zero result is always
  // forced to +0, which also makes a -0 operand behave exactly like +0.
  always_comb begin
    signAcc = acc_q[N-1];
    magAcc  = acc_q[MW-1:0];
    signIn  = in_data[N-1];
    magIn   = in_data[MW-1:0];
    magSum  = {1'b0, magAcc} + {1'b0, magIn};
    signRes = 1'b0;
    magRes  = '0;
    addOvf  = 1'b0;
    if (signAcc == signIn) begin
      signRes = signAcc;
      if (magSum[N-1]) begin
        magRes = MAG_MAX;
        addOvf = 1'b1;
      end else begin
        magRes = magSum[MW-1:0];
      end
    end else if (magAcc > magIn) begin
      signRes = signAcc;
      magRes  = magAcc - magIn;
    end else begin
      signRes = signIn;
      magRes  = magIn - magAcc;
    end
    if (magRes == '0) begin
      signRes = 1'b0;
    end
  end

  // Index of the final term; only consulted in ACC, where len_q >= 1.
  assign lenLast = len_q - 1'b1;

  // Next-state logic for the sequencer and the datapath registers.
  // Everything holds by default; each state only overrides what it owns.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = {signRes, magRes};
          ovf_d = ovf_q | addOvf;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == lenLast) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs depend on registered state only, so neither handshake input
  // has a combinational path to in_ready or out_valid. The result fields
  // read as zero outside DONE.
  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
    busy      = (state_q == ACC) || (state_q == DONE);
    out_sum   = (state_q == DONE) ? acc_q : '0;
    out_ovf   = (state_q == DONE) && ovf_q;
  end

endmodule

// File: doc/sign_mag_accum_ctrl.md
# sign_mag_accum_ctrl

Sequential controller that accumulates a programmed number of N-bit sign-magnitude operands. It feeds them one per cycle through a single shared sign-magnitude add step and returns the final sum with a sticky overflow flag. It sits between an operand stream source and a result consumer, and uses valid/ready handshakes on both sides. It owns the sequencing (start, term counting, completion) that the bare combinational sign-magnitude adder lacks.

## Interface
- N, default 8: operand/result width; bit N-1 is the sign (1 = negative), bits N-2:0 are the magnitude.
- CNT_W, default 4: width of the term-count field.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command to begin a new accumulation; honoured only in IDLE.
- len  in  CNT_W  number of terms to accumulate; sampled when start is honoured.
- in_data  in  N  sign-magnitude operand.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  controller accepts an operand this cycle.
- out_sum  out  N  final sign-magnitude sum.
- out_ovf  out  1  sticky flag: at least one add in this run saturated.
- out_valid  out  1  out_sum/out_ovf are valid.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in ACC or DONE.

## Operation
- FSM states are IDLE, ACC and DONE.
- **Reset:** state IDLE. acc = 0, cnt = 0, ovf = 0. All outputs 0 (in_ready, out_valid, busy, out_sum, out_ovf).
- **IDLE:**
  - in_ready = 0.
  - On start: latch len, clear acc to +0, cnt to 0 and ovf to 0.
  - Next state is DONE if len == 0, otherwise ACC.
- **ACC:**
  - in_ready = 1.
  - A transfer occurs when in_valid && in_ready. On a transfer: acc <= acc ⊕ in_data, and cnt <= cnt + 1.
  - When a transfer occurs with cnt == len − 1, go to DONE.
  - in_valid low stalls without state change.
- **DONE:**
  - out_valid = 1.
  - out_sum = acc and out_ovf = ovf, held stable until out_ready.
  - On out_ready, go to IDLE.
- start is ignored in ACC and DONE, including any start coincident with out_ready in DONE.
- **Add step ⊕** (combinational, one per cycle):
  - Split both operands into sign and magnitude.
  - The larger magnitude supplies the result sign. On equal magnitudes, the in_data sign is used before zero normalisation.
  - Same signs: result magnitude = mag_acc + mag_in, computed N bits wide. If the result exceeds 2^(N−1)−1, clamp the magnitude to 2^(N−1)−1, keep the sign, and set ovf.
  - Different signs: result magnitude = max − min. This case never overflows.
  - Zero normalisation: a zero magnitude result always has sign 0, so −0 is never produced. A −0 input is treated as +0.
- After saturation, accumulation continues from the clamped value.
- **Mid-operation reset:** reset in any state returns to the reset condition on the next edge. The partial sum is discarded.

## Timing
- start is accepted on edge T. in_ready is high from cycle T+1.
- Throughput is one operand per cycle while in_valid stays high.
- The last operand is accepted on edge T'. out_valid is high from cycle T'+1, giving 1-cycle result latency.
- With len == 0, out_valid is high in cycle T+1 and out_sum = 0.
- A result is accepted on edge R (out_valid && out_ready). State is IDLE in R+1, so the earliest next start is sampled in R+1.
- in_ready and out_valid are never high in the same cycle.
- Outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to in_ready or out_valid.

## Test plan
Parameters N = 8, CNT_W = 4.
1. Mixed signs: start, len = 3, terms 8'h05, 8'h83, 8'h0A with in_valid held high -> out_valid exactly 1 cycle after the 3rd transfer; out_sum = 8'h0C, out_ovf = 0.
2. Overflow: len = 3, terms 8'h64, 8'h32, 8'h85 -> the 2nd add clamps to 8'h7F; final out_sum = 8'h7A, out_ovf = 1.
3. Cancellation: len = 2, terms 8'h14, 8'h94 -> out_sum = 8'h00 (not 8'h80).
4. Empty run and ignored start: len = 0 -> out_valid in the cycle after start, out_sum = 8'h00. Separately, pulse start during ACC -> no effect on cnt or acc.
5. Back-pressure and gaps: len = 4 with in_valid deasserted for 2 cycles between terms, and out_ready low for 5 cycles in DONE -> no term lost or duplicated; out_sum and out_ovf stable while out_ready is low; IDLE entered 1 cycle after out_ready.
6. Reset mid-run: assert reset after 2 of 5 terms -> next cycle all outputs 0 and state IDLE. A new run with len = 1, term 8'h81 -> out_sum = 8'h81, out_ovf = 0.
